multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the softcore's single-cycle control decoder. It sequences each RV32I instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, with req/ack handshakes on the instruction and data buses. It registers its decode outputs, adds legality checking, traps and bus-timeout detection, and drives the datapath muxes and write enables. It sits between the instruction register/bus interfaces and the datapath.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a bus request is held without ack before trapping; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived).
TRAP_ON_SYSTEM, 1, 1 = ECALL/EBREAK trap; 0 = executed as NOP.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
opcode_i  in  7  instr[6:0] from IR
funct3_i  in  3  instr[14:12]
funct7_i  in  7  instr[31:25]
instr_ack_i  in  1  instruction bus ack
data_ack_i  in  1  data bus ack
branch_taken_i  in  1  comparator result, valid in EXECUTE
instr_req_o  out  1  instruction bus request
ir_write_enable_o  out  1  load IR
data_req_o  out  1  data bus request
mem_write_enable_o  out  1  store qualifier, valid with data_req_o
reg_write_enable_o  out  1  regfile write pulse
alu_src_1_o  out  1  0 = rs1, 1 = PC
alu_src_2_o  out  2  00 imm_i, 01 imm_s, 10 imm_u, 11 rs2
alu_op_o  out  2  00 add, 01 R-type funct, 10 I-type funct, 11 branch compare
reg_write_src_o  out  2  00 imm_u, 01 alu, 10 dmem, 11 PC+4
pc_src_o  out  2  00 PC+4, 01 PC+imm, 11 (rs1+imm)&~1
pc_write_enable_o  out  1  PC update, one pulse per retired instruction
instr_retired_o  out  1  retire pulse
trap_o  out  1  one-cycle trap pulse
trap_cause_o  out  2  00 illegal, 01 system, 10 ibus timeout, 11 dbus timeout
halted_o  out  1  core halted

Behaviour:
- Reset: async; state goes to FETCH, every output 0, counter 0. Requests in flight are dropped. The first cycle after release asserts instr_req_o.
- FETCH: hold instr_req_o until instr_ack_i. On the ack cycle, pulse ir_write_enable_o and go to DECODE.
- DECODE: register all decode outputs from opcode/funct. They hold stable until the next FETCH.
- Illegal cases trap:
  - unknown opcode;
  - OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101;
  - OP-IMM shifts with a bad funct7;
  - LOAD funct3 not in {000,001,010,100,101};
  - STORE funct3 > 010;
  - BRANCH funct3 010/011;
  - JALR funct3 != 000.
- EXECUTE routing:
  - LUI, AUIPC, OP, OP-IMM, JAL, JALR go to WRITEBACK.
  - LOAD/STORE go to MEM.
  - BRANCH/FENCE pulse pc_write_enable_o and instr_retired_o, then go to FETCH. For BRANCH, pc_src_o = 01 if branch_taken_i else 00.
- MEM: hold data_req_o until data_ack_i; mem_write_enable_o = 1 only for STORE.
  - STORE ack: pulse pc_write_enable_o and instr_retired_o, go to FETCH.
  - LOAD ack: go to WRITEBACK.
- WRITEBACK: one cycle; pulse reg_write_enable_o, pc_write_enable_o and instr_retired_o; go to FETCH. pc_src_o = 01 for JAL, 11 for JALR, else 00.
- Minimum latency (instruction bus ack in the first cycle): ALU/jump 4 cycles, LOAD 5, STORE 4, BRANCH/FENCE 3.
- Timeout:
  - Counter clears on entering FETCH/MEM and increments each cycle the request is unacked.
  - If counter == TIMEOUT_CYCLES-1 with no ack, trap next cycle. The request is therefore high exactly TIMEOUT_CYCLES cycles.
  - Ack in that last cycle wins; no trap.
- TRAP: one cycle with trap_o=1 and cause set, then HALT. HALT asserts halted_o=1 and all enables/requests 0 until reset.
- Acks arriving outside the matching wait state are ignored. rd=x0 suppression is the regfile's job.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams;
  - state encoding (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP, HALT);
  - alu_src_2, alu_op, reg_write_src, pc_src and trap_cause encodings.
- Sub-module instr_decoder is combinational: opcode/funct to decode word plus legal/system flags. The FSM registers its output in DECODE.

Test Plan:
1. ADD (0110011/000/0000000), instr_ack on first cycle -> ir_write_enable_o cycle 0, reg_write_enable_o cycle 3, alu_src_2_o=11, reg_write_src_o=01, one instr_retired_o.
2. LW (0000011/010), data_ack_i 3 cycles late -> data_req_o high 4 cycles, mem_write_enable_o=0, then WRITEBACK with reg_write_src_o=10.
3. BEQ with branch_taken_i=1 -> pc_src_o=01 and pc_write_enable_o in EXECUTE, no reg write. Repeat with 0 -> pc_src_o=00.
4. OP with funct7=0000001 -> trap_o one cycle, cause 00, then halted_o=1; no reg/mem/pc writes; instr_req_o stays 0.
5. TIMEOUT_CYCLES=4, no instr_ack -> instr_req_o high 4 cycles, then trap cause 10. Rerun with ack in cycle 4 -> no trap.
6. SW (0100011/010), rst_n_i low mid-MEM -> data_req_o and mem_write_enable_o drop immediately; after release, instr_req_o=1 the next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// opcodes, FSM states, datapath mux selects, trap causes and the decode word.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    SRC2_IMM_I = 2'b00,
    SRC2_IMM_S = 2'b01,
    SRC2_IMM_U = 2'b10,
    SRC2_RS2   = 2'b11
  } alu_src_2_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_RTYPE  = 2'b01,
    ALU_ITYPE  = 2'b10,
    ALU_BRANCH = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WSRC_IMM_U = 2'b00,
    WSRC_ALU   = 2'b01,
    WSRC_DMEM  = 2'b10,
    WSRC_PC4   = 2'b11
  } reg_write_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_REL   = 2'b01,
    PC_JALR  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'b00,
    CAUSE_SYSTEM  = 2'b01,
    CAUSE_IBUS_TO = 2'b10,
    CAUSE_DBUS_TO = 2'b11
  } trap_cause_e;

  // Where EXECUTE sends the instruction next.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NOP
  } instr_class_e;

  typedef struct packed {
    logic           alu_src_1;
    alu_src_2_e     alu_src_2;
    alu_op_e        alu_op;
    reg_write_src_e reg_write_src;
    pc_src_e        pc_src;
    instr_class_e   cls;
  } decode_t;

  localparam decode_t DECODE_NONE = '{
    alu_src_1:     1'b0,
    alu_src_2:     SRC2_IMM_I,
    alu_op:        ALU_ADD,
    reg_write_src: WSRC_IMM_U,
    pc_src:        PC_PLUS4,
    cls:           CLS_NOP
  };

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode: opcode/funct fields to the datapath decode word,
// plus legality and ECALL/EBREAK flags. Registered by the sequencer in DECODE.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_SYSTEM = 1'b1
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output decode_t    dec_o,
  output logic       legal_o,
  output logic       system_o
);

  always_comb begin
    dec_o    = DECODE_NONE;
    legal_o  = 1'b1;
    system_o = 1'b0;
    case (opcode_i)
      OPC_LUI: begin
        dec_o.alu_src_2     = SRC2_IMM_U;
        dec_o.reg_write_src = WSRC_IMM_U;
        dec_o.cls           = CLS_ALU;
      end
      OPC_AUIPC: begin
        dec_o.alu_src_1     = 1'b1;
        dec_o.alu_src_2     = SRC2_IMM_U;
        dec_o.reg_write_src = WSRC_ALU;
        dec_o.cls           = CLS_ALU;
      end
      OPC_OP: begin
        dec_o.alu_src_2     = SRC2_RS2;
        dec_o.alu_op        = ALU_RTYPE;
        dec_o.reg_write_src = WSRC_ALU;
        dec_o.cls           = CLS_ALU;
        if (funct7_i == 7'b0100000)
          legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b101);
        else
          legal_o = (funct7_i == 7'b0000000);
      end
      OPC_OP_IMM: begin
        dec_o.alu_op        = ALU_ITYPE;
        dec_o.reg_write_src = WSRC_ALU;
        dec_o.cls           = CLS_ALU;
        // funct7 only carries meaning for the shift-immediate forms.
        if (funct3_i == 3'b001)
          legal_o = (funct7_i == 7'b0000000);
        else if (funct3_i == 3'b101)
          legal_o = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
      end
      OPC_JAL: begin
        dec_o.alu_src_1     = 1'b1;
        dec_o.reg_write_src = WSRC_PC4;
        dec_o.pc_src        = PC_REL;
        dec_o.cls           = CLS_ALU;
      end
      OPC_JALR: begin
        dec_o.reg_write_src = WSRC_PC4;
        dec_o.pc_src        = PC_JALR;
        dec_o.cls           = CLS_ALU;
        legal_o             = (funct3_i == 3'b000);
      end
      OPC_LOAD: begin
        dec_o.reg_write_src = WSRC_DMEM;
        dec_o.cls           = CLS_LOAD;
        legal_o = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        dec_o.alu_src_2 = SRC2_IMM_S;
        dec_o.cls       = CLS_STORE;
        legal_o         = (funct3_i <= 3'b010);
      end
      OPC_BRANCH: begin
        dec_o.alu_src_2 = SRC2_RS2;
        dec_o.alu_op    = ALU_BRANCH;
        dec_o.cls       = CLS_BRANCH;
        legal_o         = (funct3_i != 3'b010) && (funct3_i != 3'b011);
      end
      OPC_FENCE: begin
        dec_o.cls = CLS_NOP;
      end
      OPC_SYSTEM: begin
        // No CSR support: only the funct3=000 ECALL/EBREAK group is legal.
        dec_o.cls = CLS_NOP;
        if (funct3_i != 3'b000)
          legal_o = 1'b0;
        else
          system_o = TRAP_ON_SYSTEM;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// bus req/ack handshakes, legality traps and bus-timeout detection.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1,
  parameter bit          TRAP_ON_SYSTEM = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       instr_ack_i,
  input  logic       data_ack_i,
  input  logic       branch_taken_i,
  output logic       instr_req_o,
  output logic       ir_write_enable_o,
  output logic       data_req_o,
  output logic       mem_write_enable_o,
  output logic       reg_write_enable_o,
  output logic       alu_src_1_o,
  output logic [1:0] alu_src_2_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] reg_write_src_o,
  output logic [1:0] pc_src_o,
  output logic       pc_write_enable_o,
  output logic       instr_retired_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic       halted_o
);

  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  decode_t          dec_q;
  decode_t          dec_w;
  logic             legal_w;
  logic             system_w;
  logic             instr_req_q;
  logic             data_req_q;
  logic             mem_we_q;
  logic             wb_q;
  logic             trap_q;
  logic             halted_q;
  trap_cause_e      cause_q;
  logic             ex_retire;
  logic             st_retire;
  logic             to_hit;

  instr_decoder #(
    .TRAP_ON_SYSTEM (TRAP_ON_SYSTEM)
  ) u_decoder (
    .opcode_i (opcode_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .dec_o    (dec_w),
    .legal_o  (legal_w),
    .system_o (system_w)
  );

  assign to_hit = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_FETCH;
      cnt_q       <= '0;
      dec_q       <= DECODE_NONE;
      instr_req_q <= 1'b0;
      data_req_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      wb_q        <= 1'b0;
      trap_q      <= 1'b0;
      halted_q    <= 1'b0;
      cause_q     <= CAUSE_ILLEGAL;
    end else begin
      wb_q   <= 1'b0;
      trap_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          // The request is raised on entry; only the post-reset cycle arrives here with it low.
          if (!instr_req_q) begin
            instr_req_q <= 1'b1;
            cnt_q       <= '0;
          end else if (instr_ack_i) begin
            instr_req_q <= 1'b0;
            state_q     <= ST_DECODE;
          end else if (to_hit) begin
            instr_req_q <= 1'b0;
            trap_q      <= 1'b1;
            cause_q     <= CAUSE_IBUS_TO;
            state_q     <= ST_TRAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          dec_q <= dec_w;
          if (!legal_w) begin
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
            state_q <= ST_TRAP;
          end else if (system_w) begin
            trap_q  <= 1'b1;
            cause_q <= CAUSE_SYSTEM;
            state_q <= ST_TRAP;
          end else begin
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (dec_q.cls)
            CLS_ALU: begin
              wb_q    <= 1'b1;
              state_q <= ST_WRITEBACK;
            end
            CLS_LOAD, CLS_STORE: begin
              data_req_q <= 1'b1;
              mem_we_q   <= (dec_q.cls == CLS_STORE);
              cnt_q      <= '0;
              state_q    <= ST_MEM;
            end
            default: begin
              instr_req_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (data_ack_i) begin
            data_req_q <= 1'b0;
            mem_we_q   <= 1'b0;
            if (mem_we_q) begin
              instr_req_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_FETCH;
            end else begin
              wb_q    <= 1'b1;
              state_q <= ST_WRITEBACK;
            end
          end else if (to_hit) begin
            data_req_q <= 1'b0;
            mem_we_q   <= 1'b0;
            trap_q     <= 1'b1;
            cause_q    <= CAUSE_DBUS_TO;
            state_q    <= ST_TRAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WRITEBACK: begin
          instr_req_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_FETCH;
        end
        ST_TRAP: begin
          halted_q <= 1'b1;
          state_q  <= ST_HALT;
        end
        ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          halted_q <= 1'b1;
          state_q  <= ST_HALT;
        end
      endcase
    end
  end

  // Handshake-qualified strobes must land in the ack/compare cycle itself.
  assign ex_retire = (state_q == ST_EXECUTE) && ((dec_q.cls == CLS_BRANCH) || (dec_q.cls == CLS_NOP));
  assign st_retire = data_req_q && mem_we_q && data_ack_i;

  assign instr_req_o        = instr_req_q;
  assign ir_write_enable_o  = instr_req_q && instr_ack_i;
  assign data_req_o         = data_req_q;
  assign mem_write_enable_o = mem_we_q;
  assign reg_write_enable_o = wb_q;
  assign pc_write_enable_o  = wb_q || ex_retire || st_retire;
  assign instr_retired_o    = wb_q || ex_retire || st_retire;
  assign trap_o             = trap_q;
  assign trap_cause_o       = cause_q;
  assign halted_o           = halted_q;

  assign alu_src_1_o     = dec_q.alu_src_1;
  assign alu_src_2_o     = dec_q.alu_src_2;
  assign alu_op_o        = dec_q.alu_op;
  assign reg_write_src_o = dec_q.reg_write_src;
  assign pc_src_o        = ((state_q == ST_EXECUTE) && (dec_q.cls == CLS_BRANCH))
                           ? (branch_taken_i ? PC_REL : PC_PLUS4)
                           : dec_q.pc_src;

endmodule
